// File: rtl/param_seq_addsub.sv
// Multi-cycle add/subtract unit: operands latched on a valid/ready handshake,
// summed CHUNK bits per clock through a registered carry, result held until accepted.
module param_seq_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  output logic             o_valid,
  input  logic             i_res_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SUM_W  = CHUNK + 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("param_seq_addsub: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               accept_c;
  logic               step_c;
  logic               handoff_c;
  logic               last_c;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sub_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     result_q;
  logic               ovf_q;
  logic               valid_q;
  logic               ready_q;

  logic [CHUNK-1:0]   a_chunk_c;
  logic [CHUNK-1:0]   b_chunk_c;
  logic [SUM_W-1:0]   sum_c;
  logic               msb_cin_c;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    handoff_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          accept_c = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        step_c = 1'b1;
        if (last_c) state_d = DONE;
      end
      DONE: begin
        if (i_res_ready) begin
          handoff_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_c = (cnt_q == CNT_W'(NCHUNK - 1));

  // One chunk of the ripple sum; the MSB carry-in is recovered from the sum bit
  assign a_chunk_c = CHUNK'(a_q >> (cnt_q * CHUNK));
  assign b_chunk_c = CHUNK'(b_q >> (cnt_q * CHUNK));
  assign sum_c     = SUM_W'(a_chunk_c) + SUM_W'(b_chunk_c) + SUM_W'(carry_q);
  assign msb_cin_c = a_chunk_c[CHUNK-1] ^ b_chunk_c[CHUNK-1] ^ sum_c[CHUNK-1];

  // Operand latch, chunk datapath and result/flag registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      ready_q <= (state_d == IDLE);
      if (accept_c) begin
        a_q     <= i_add_term1;
        b_q     <= i_sub ? ~i_add_term2 : i_add_term2;
        sub_q   <= i_sub;
        carry_q <= i_sub;
        cnt_q   <= '0;
      end
      if (step_c) begin
        result_q[cnt_q*CHUNK +: CHUNK] <= sum_c[CHUNK-1:0];
        carry_q                        <= sum_c[CHUNK];
        cnt_q                          <= cnt_q + CNT_W'(1);
        if (last_c) begin
          // Subtract reports borrow, the inverse of the final carry-out
          result_q[WIDTH] <= sum_c[CHUNK] ^ sub_q;
          ovf_q           <= msb_cin_c ^ sum_c[CHUNK];
          valid_q         <= 1'b1;
        end
      end
      if (handoff_c) valid_q <= 1'b0;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/param_seq_addsub.md
Name: param_seq_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit; successor to the combinational ripple adder.
- Operands are latched on a valid/ready handshake, then summed CHUNK bits per clock with a registered carry between chunks.
- The result is held with a carry/borrow bit and a signed-overflow flag until downstream accepts it.
- Used where a full-width combinational carry chain would not meet timing on the MAX 10 fabric.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 1.
- CHUNK, 4, bits summed per clock. WIDTH must be a multiple of CHUNK, else elaboration error.
- NCHUNK (localparam) = WIDTH/CHUNK, the number of processing cycles.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  request: operands and mode valid.
- o_ready  output  1  unit can accept a request.
- i_sub  input  1  0 = add, 1 = subtract (term1 - term2).
- i_add_term1  input  WIDTH  operand A.
- i_add_term2  input  WIDTH  operand B.
- o_valid  output  1  result valid.
- i_res_ready  input  1  downstream accepts result.
- o_result  output  WIDTH+1  bit WIDTH = carry (add) or borrow (sub); bits WIDTH-1:0 = sum/difference.
- o_overflow  output  1  two's-complement signed overflow of the WIDTH-bit result.

Behaviour:
- One clock domain. Reset is synchronous, active-high, sampled on the i_clk rising edge.
- Reset values: state IDLE; o_valid 0; o_result 0; o_overflow 0; chunk counter 0; carry register 0.
- o_ready is 1 in IDLE (and in the cycle after reset), and 0 otherwise.
- States:
  - IDLE -> BUSY on an edge with i_valid & o_ready. On that edge: latch A; latch B, or ~B when i_sub=1; latch i_sub; carry register <= i_sub (the +1 for subtract); counter <= 0.
  - BUSY: each edge sums chunk[counter] of A, B and the carry register. It writes the CHUNK sum bits into the result register and the chunk carry-out into the carry register, then increments the counter. Chunk 0 is the LSBs.
  - BUSY -> DONE on the edge processing chunk NCHUNK-1. On that same edge, set o_valid = 1 and:
    - o_result[WIDTH] = cout when add; ~cout when sub.
    - o_overflow = carry-into-MSB XOR carry-out-of-MSB.
  - DONE -> IDLE on an edge with i_res_ready = 1; o_valid <= 0.
- Holding rules:
  - o_result and o_overflow hold their values while o_valid = 1 and i_res_ready = 0.
  - Both keep their last values after handoff; they are only meaningful while o_valid = 1.
- Latency: o_valid rises exactly NCHUNK edges after the accept edge. With CHUNK = WIDTH, latency is 1.
- Throughput: one operation per NCHUNK + 2 cycles minimum. No accept in the handoff cycle.
- Inputs ignored while not in IDLE: i_valid, the operands and i_sub. Changing them mid-operation must not affect the result.
- i_res_ready is ignored outside DONE.
- Reset mid-operation (BUSY or DONE): the operation is abandoned, reset values apply on the next edge, and no o_valid pulse is produced.
- Arithmetic wraps modulo 2^WIDTH on the low bits; no saturation.

Test Plan:
- Add carry-out: WIDTH=16, CHUNK=4, add 0xFFFF + 0x0001. Required: o_valid rises 4 edges after accept; o_result = 0x1_0000; o_overflow = 0.
- Subtract with borrow: 0x0005 - 0x0007. Required: o_result[15:0] = 0xFFFE; o_result[16] = 1; o_overflow = 0. Then 0x0007 - 0x0005 gives 0x0_0002.
- Signed overflow, both modes:
  - add 0x7FFF + 0x0001 -> o_result = 0x0_8000, o_overflow = 1.
  - sub 0x8000 - 0x0001 -> low bits 0x7FFF, borrow 0, o_overflow = 1.
- Backpressure:
  - Hold i_res_ready = 0 for 10 cycles after o_valid. Required: o_result stable; o_ready = 0; a concurrent i_valid with new operands is not accepted.
  - Then raise i_res_ready for 1 cycle. Required: o_valid falls and o_ready returns to 1 on the next edge.
- Input stability: change operands and i_sub every cycle while BUSY. Required: result still matches the latched request.
- Reset mid-operation: assert i_reset for 1 cycle at the 2nd BUSY edge. Required: o_valid never rises; o_ready = 1 after reset; the next request 0x1234 + 0x1111 returns 0x0_2345.
- Parameter sweep with random operands (≥1000 each), checked against a reference model:
  - WIDTH=8, CHUNK=8: latency 1.
  - WIDTH=8, CHUNK=1: latency 8.
